// File: rtl/playbus_n.sv
// PlayBus emulator core: one shared bus modelled as a driver mux with float/contention flags.
// A go/busy/done handshake runs single-cycle functions (EXEC) and a full ROM->RAM block copy (BLOCK).
module playbus_n #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 3,
    parameter int ROM_MUL = 3,
    parameter int ROM_ADD = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [2:0]        sw_func,
    input  logic              go,
    output logic [DATA_W-1:0] bus,
    output logic              bus_z,
    output logic              contend,
    output logic              err,
    output logic [DATA_W-1:0] led,
    output logic [ADDR_W-1:0] addr_q,
    output logic [2:0]        func_q,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = DATA_W + ADDR_W;

    localparam logic [2:0] F_SW_LED  = 3'd1;
    localparam logic [2:0] F_SW_RAM  = 3'd2;
    localparam logic [2:0] F_RAM_LED = 3'd3;
    localparam logic [2:0] F_ROM_LED = 3'd4;
    localparam logic [2:0] F_ROM_RAM = 3'd5;
    localparam logic [2:0] F_BLOCK   = 3'd6;
    localparam logic [2:0] F_FAULT   = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, BLOCK} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [2:0]        func_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic              ram_we;
    logic [DATA_W-1:0] ram_rd;

    logic [PW-1:0]     rom_prod;
    logic [DATA_W-1:0] rom_data;

    logic              drv_sw, drv_ram, drv_rom;
    logic [1:0]        n_drv;

    // ROM is pure arithmetic on the address, widened so the product cannot overflow before truncation.
    assign rom_prod = PW'(addr_q) * PW'(ROM_MUL) + PW'(ROM_ADD);
    assign rom_data = rom_prod[DATA_W-1:0];
    assign ram_rd   = ram_q[addr_q];

    always_comb begin
        drv_sw  = 1'b0;
        drv_ram = 1'b0;
        drv_rom = 1'b0;
        case (state_q)
            EXEC: begin
                case (func_q)
                    F_SW_LED, F_SW_RAM:   drv_sw  = 1'b1;
                    F_RAM_LED:            drv_ram = 1'b1;
                    F_ROM_LED, F_ROM_RAM: drv_rom = 1'b1;
                    F_FAULT: begin
                        drv_sw  = 1'b1;
                        drv_ram = 1'b1;
                    end
                    default: ;
                endcase
            end
            BLOCK:   drv_rom = 1'b1;
            default: ;
        endcase
    end

    assign n_drv   = {1'b0, drv_sw} + {1'b0, drv_ram} + {1'b0, drv_rom};
    assign bus_z   = (n_drv == 2'd0);
    assign contend = (n_drv > 2'd1);

    // A floating or fought-over bus reads as zero.
    always_comb begin
        bus = '0;
        if (n_drv == 2'd1) begin
            if (drv_sw)       bus = sw_data;
            else if (drv_ram) bus = ram_rd;
            else              bus = rom_data;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        func_d  = func_q;
        led_d   = led_q;
        err_d   = err_q | contend;
        done_d  = 1'b0;
        ram_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    if (sw_func == F_BLOCK) begin
                        addr_d  = '0;
                        func_d  = F_BLOCK;
                        state_d = BLOCK;
                    end else begin
                        addr_d  = sw_addr;
                        func_d  = sw_func;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case (func_q)
                    F_SW_LED, F_RAM_LED, F_ROM_LED: led_d  = bus;
                    F_SW_RAM, F_ROM_RAM:            ram_we = 1'b1;
                    default: ;
                endcase
            end
            BLOCK: begin
                led_d  = bus;
                ram_we = 1'b1;
                // Last word: stop with the address parked at the top, no wrap.
                if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            func_q  <= '0;
            led_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            func_q  <= func_d;
            led_q   <= led_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // RAM keeps its contents across reset, but a reset cycle must not write it.
    always_ff @(posedge clk) begin
        if (n_reset && ram_we) ram_q[addr_q] <= bus;
    end

    assign led  = led_q;
    assign err  = err_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
endmodule
